// File: rtl/ram_loader.sv
// Streams bytes into the 256x16 RAM as high-first 16-bit words at consecutive addresses.
// Optional readback check after every write when LOADER_VERIFY_EN is defined.
module ram_loader #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter logic [7:0] LAST_ADDR  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  word_cnt
);

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, WRITE, VERIFY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, WRITE, DONE} state_t;
`endif

  state_t      state_reg, state_next;
  logic [7:0]  addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [8:0]  cnt_reg, cnt_next;
  logic        advance;

`ifdef LOADER_VERIFY_EN
  logic        err_reg, err_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= 8'h00;
      wdata_reg <= 16'h0000;
      cnt_reg   <= 9'd0;
`ifdef LOADER_VERIFY_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      cnt_reg   <= cnt_next;
`ifdef LOADER_VERIFY_EN
      err_reg   <= err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    cnt_next   = cnt_reg;
    advance    = 1'b0;
`ifdef LOADER_VERIFY_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next  = START_ADDR;
          cnt_next   = 9'd0;
`ifdef LOADER_VERIFY_EN
          err_next   = 1'b0;
`endif
          state_next = GET_HI;
        end
      end
      GET_HI: begin
        // stop only ends a load on a word boundary, so it outranks a pending byte here
        if (stop) begin
          state_next = DONE;
        end else if (byte_valid) begin
          wdata_next[15:8] = byte_data;
          state_next       = GET_LO;
        end
      end
      GET_LO: begin
        if (byte_valid) begin
          wdata_next[7:0] = byte_data;
          state_next      = WRITE;
        end
      end
      WRITE: begin
`ifdef LOADER_VERIFY_EN
        state_next = VERIFY;
`else
        advance    = 1'b1;
`endif
      end
`ifdef LOADER_VERIFY_EN
      VERIFY: begin
        if (ram_rdata != wdata_reg) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          advance    = 1'b1;
        end
      end
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // address is held at LAST_ADDR rather than wrapping back to 8'h00
    if (advance) begin
      cnt_next = cnt_reg + 9'd1;
      if (addr_reg == LAST_ADDR || stop) begin
        state_next = DONE;
      end else begin
        addr_next  = addr_reg + 8'd1;
        state_next = GET_HI;
      end
    end
  end

  assign byte_ready = (state_reg == GET_HI) || (state_reg == GET_LO);
  assign ram_we     = (state_reg == WRITE);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign ram_addr   = addr_reg;
  assign ram_wdata  = wdata_reg;
  assign word_cnt   = cnt_reg;

`ifdef LOADER_VERIFY_EN
  assign err = err_reg;
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: two instances (default window and FE..FF window) share one RAM model.
// Build with LOADER_VERIFY_EN defined to also exercise the readback-check path.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        sel = 1'b0;
  logic        corrupt = 1'b0;
  logic        clr_req = 1'b0;
  logic [15:0] mem [256];

  logic        start_a, valid_a, ready_a, we_a, busy_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [15:0] wdata_a, rdata_a;
  logic [8:0]  cnt_a;
  logic        start_b, valid_b, ready_b, we_b, busy_b, done_b, err_b;
  logic [7:0]  addr_b;
  logic [15:0] wdata_b, rdata_b;
  logic [8:0]  cnt_b;

  logic        ready_s, we_s, busy_s, done_s, err_s;
  logic [7:0]  addr_s;
  logic [15:0] wdata_s;
  logic [8:0]  cnt_s;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  logic [23:0] sb [$];
  logic [7:0]  exp_addr;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign valid_a = byte_valid & ~sel;
  assign valid_b = byte_valid & sel;
  assign rdata_a = mem[addr_a];
  assign rdata_b = mem[addr_b];

  assign ready_s = sel ? ready_b : ready_a;
  assign we_s    = sel ? we_b    : we_a;
  assign busy_s  = sel ? busy_b  : busy_a;
  assign done_s  = sel ? done_b  : done_a;
  assign err_s   = sel ? err_b   : err_a;
  assign addr_s  = sel ? addr_b  : addr_a;
  assign wdata_s = sel ? wdata_b : wdata_a;
  assign cnt_s   = sel ? cnt_b   : cnt_a;

  ram_loader u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop),
    .byte_valid(valid_a), .byte_data(byte_data), .byte_ready(ready_a),
    .ram_we(we_a), .ram_addr(addr_a), .ram_wdata(wdata_a), .ram_rdata(rdata_a),
    .busy(busy_a), .done(done_a), .err(err_a), .word_cnt(cnt_a)
  );

  ram_loader #(.START_ADDR(8'hFE), .LAST_ADDR(8'hFF)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop),
    .byte_valid(valid_b), .byte_data(byte_data), .byte_ready(ready_b),
    .ram_we(we_b), .ram_addr(addr_b), .ram_wdata(wdata_b), .ram_rdata(rdata_b),
    .busy(busy_b), .done(done_b), .err(err_b), .word_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model captures on negedge; also the scoreboard consumer and pulse counters
  always @(negedge clk) begin
    logic [23:0] e;
    if (clr_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hDEAD;
    end else begin
      if (we_a) mem[addr_a] <= (corrupt && addr_a == 8'h01) ? (wdata_a ^ 16'h0100) : wdata_a;
      if (we_b) mem[addr_b] <= wdata_b;
    end
    if (we_s) begin
      we_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_we", 32'(addr_s), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(addr_s), 32'(e[23:16]));
        check("wr_data", 32'(wdata_s), 32'(e[15:0]));
        $display("write addr=%02h data=%04h", addr_s, wdata_s);
      end
    end
    if ((we_a && sel) || (we_b && !sel)) check("idle_inst_we", 32'd1, 32'd0);
    if (done_s) done_cnt++;
  end

  task automatic clear_ram();
    @(posedge clk); #1 clr_req = 1'b1;
    @(negedge clk); #1 clr_req = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] first);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_addr = first;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    @(negedge clk);
    while (!ready_s && n < 40) begin n++; @(negedge clk); end
    ok = ready_s;
    if (ok) begin @(posedge clk); #1; end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    bit ok;
    send_byte(w[15:8], gap, ok);
    check("hi_taken", 32'(ok), 32'd1);
    sb.push_back({exp_addr, w});
    send_byte(w[7:0], gap, ok);
    check("lo_taken", 32'(ok), 32'd1);
    exp_addr = exp_addr + 8'd1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_s && n < 40) begin @(negedge clk); n++; end
    check("done_seen", 32'(done_s), 32'd1);
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    check("busy_after_done", 32'(busy_s), 32'd0);
  endtask

  task automatic pulse_reset_checks();
    @(negedge clk); #2 rst = 1'b0;
    #1;
    check("rst_we", 32'(we_s), 32'd0);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_ready", 32'(ready_s), 32'd0);
    check("rst_addr", 32'(addr_s), 32'd0);
    check("rst_cnt", 32'(cnt_s), 32'd0);
    check("rst_done", 32'(done_s), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int we_base, done_base;
    bit ok;
    logic [15:0] words [2];
    words[0] = 16'h02A0;
    words[1] = 16'h01A5;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("init_busy", 32'(busy_a), 32'd0);
    check("init_ready", 32'(ready_a), 32'd0);
    check("init_we", 32'(we_a), 32'd0);
    check("init_addr", 32'(addr_a), 32'd0);
    check("init_wdata", 32'(wdata_a), 32'd0);
    check("init_cnt", 32'(cnt_a), 32'd0);
    check("init_err", 32'(err_a), 32'd0);
    @(negedge clk) rst = 1'b1;
    clear_ram();

    // basic two-word load, stop after the last low byte
    we_base = we_cnt; done_base = done_cnt;
    do_start(8'h00);
    for (int i = 0; i < 2; i++) send_word(words[i], 0);
    stop = 1'b1;
    wait_done();
    check("t2_mem00", 32'(mem[0]), 32'h02A0);
    check("t2_mem01", 32'(mem[1]), 32'h01A5);
    check("t2_cnt", 32'(cnt_s), 32'd2);
    check("t2_we_cnt", 32'(we_cnt - we_base), 32'd2);
    check("t2_done_cnt", 32'(done_cnt - done_base), 32'd1);
    check("t2_err", 32'(err_s), 32'd0);

    // same stream with byte_valid gaps
    clear_ram();
    we_base = we_cnt;
    do_start(8'h00);
    for (int i = 0; i < 2; i++) send_word(words[i], 1 + i * 2);
    stop = 1'b1;
    wait_done();
    check("t3_mem00", 32'(mem[0]), 32'h02A0);
    check("t3_mem01", 32'(mem[1]), 32'h01A5);
    check("t3_mem02", 32'(mem[2]), 32'hDEAD);
    check("t3_we_cnt", 32'(we_cnt - we_base), 32'd2);

    // top-of-window instance: ends at LAST_ADDR, never wraps
    clear_ram();
    sel = 1'b1;
    we_base = we_cnt;
    do_start(8'hFE);
    send_word(16'hA1B2, 0);
    send_word(16'hC3D4, 0);
    wait_done();
    send_byte(8'h55, 0, ok);
    check("t4_third_refused", 32'(ok), 32'd0);
    check("t4_memFE", 32'(mem[254]), 32'hA1B2);
    check("t4_memFF", 32'(mem[255]), 32'hC3D4);
    check("t4_mem00", 32'(mem[0]), 32'hDEAD);
    check("t4_addr", 32'(addr_s), 32'hFF);
    check("t4_cnt", 32'(cnt_s), 32'd2);
    check("t4_we_cnt", 32'(we_cnt - we_base), 32'd2);
    sel = 1'b0;

`ifdef LOADER_VERIFY_EN
    // corrupted write at RAM[01] is caught by readback
    clear_ram();
    corrupt = 1'b1;
    do_start(8'h00);
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    wait_done();
    check("t5_err", 32'(err_s), 32'd1);
    check("t5_cnt", 32'(cnt_s), 32'd1);
    corrupt = 1'b0;
    do_start(8'h00);
    @(negedge clk);
    check("t5_err_cleared", 32'(err_s), 32'd0);
    stop = 1'b1;
    wait_done();
`endif

    // reset mid-run with a word already committed
    clear_ram();
    do_start(8'h00);
    send_word(16'h1234, 0);
    send_byte(8'h56, 0, ok);
    pulse_reset_checks();
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // reset after one high byte: nothing written, next load restarts at START_ADDR
    clear_ram();
    we_base = we_cnt;
    do_start(8'h00);
    send_byte(8'h08, 0, ok);
    pulse_reset_checks();
    check("t6_no_we", 32'(we_cnt - we_base), 32'd0);
    do_start(8'h00);
    send_word(16'h0977, 0);
    stop = 1'b1;
    wait_done();
    check("t6_mem00", 32'(mem[0]), 32'h0977);
    check("t6_mem01", 32'(mem[1]), 32'hDEAD);
    check("t6_cnt", 32'(cnt_s), 32'd1);

    // start and stop together: load begins and ends empty
    we_base = we_cnt; done_base = done_cnt;
    @(posedge clk); #1 begin start = 1'b1; stop = 1'b1; end
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    check("t7_cnt", 32'(cnt_s), 32'd0);
    check("t7_we_cnt", 32'(we_cnt - we_base), 32'd0);
    check("t7_done_cnt", 32'(done_cnt - done_base), 32'd1);

    repeat (2) @(posedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
